// File: rtl/tlp_requester.sv
// tlp_requester: turns single-DW memory read/write commands into 3DW PCIe TLPs
// on a 64-bit TX stream, and parses the 64-bit RX stream for read completions
// (CplD) and inbound memory writes (counted). Only one read is outstanding.
module tlp_requester #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        pcieClk_in,
    input  logic        pcieRstN_in,
    input  logic [15:0] cfgReqID_in,
    input  logic [31:0] cmdAddr_in,
    input  logic [31:0] cmdWrData_in,
    input  logic        cmdWrite_in,
    input  logic        cmdValid_in,
    output logic        cmdReady_out,
    output logic [31:0] rspData_out,
    output logic        rspError_out,
    output logic        rspValid_out,
    input  logic        rspReady_in,
    output logic [63:0] txData_out,
    output logic        txValid_out,
    input  logic        txReady_in,
    output logic        txSOP_out,
    output logic        txEOP_out,
    input  logic [63:0] rxData_in,
    input  logic        rxValid_in,
    output logic        rxReady_out,
    input  logic        rxSOP_in,
    input  logic        rxEOP_in,
    output logic [15:0] mwrCount_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_QW1, S_WAIT_CPL, S_RSP} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_CPL1, R_DRAIN} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic             live_q, live_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [7:0]       tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       status_q, status_d;
    logic [15:0]      mwr_cnt_q, mwr_cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             rx_beat;
    logic [1:0]       rx_fmt;
    logic [4:0]       rx_type;
    logic [7:0]       out_tag;
    logic             cpl_match;
    logic [63:0]      qw0;
    logic [63:0]      qw1;

    // live_q rises on the first edge after reset so both ready outputs stay low in reset
    assign live_d       = 1'b1;
    assign rxReady_out  = live_q;
    assign rx_beat      = rxValid_in & live_q;
    assign rx_fmt       = rxData_in[30:29];
    assign rx_type      = rxData_in[28:24];
    // the tag is bumped when the read QW1 is accepted, so the outstanding one is one behind
    assign out_tag      = tag_q - 8'd1;
    assign mwrCount_out = mwr_cnt_q;
    assign rspData_out  = rsp_data_q;
    assign rspError_out = rsp_err_q;

    assign qw0 = {cfgReqID_in, tag_q, 4'h0, 4'hF,
                  1'b0, (write_q ? 2'b10 : 2'b00), 5'h00, 14'h0000, 10'd1};
    assign qw1 = {(write_q ? wdata_q : 32'h0000_0000), addr_q, 2'b00};

    // state and datapath registers
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            tx_state_q <= S_IDLE;
            rx_state_q <= R_IDLE;
            live_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            tag_q      <= '0;
            cnt_q      <= '0;
            status_q   <= '0;
            mwr_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            live_q     <= live_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            status_q   <= status_d;
            mwr_cnt_q  <= mwr_cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // RX parser: classify each TLP on its SOP beat, check CplD tag on the second beat
    always_comb begin
        rx_state_d = rx_state_q;
        status_d   = status_q;
        mwr_cnt_d  = mwr_cnt_q;
        cpl_match  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_beat && rxSOP_in) begin
                    if (rx_fmt == 2'b10 && rx_type == 5'h0A) begin
                        status_d = rxData_in[47:45];
                        if (!rxEOP_in) rx_state_d = R_CPL1;
                    end else begin
                        if (rx_fmt[1] && rx_type == 5'h00) mwr_cnt_d = mwr_cnt_q + 16'd1;
                        if (!rxEOP_in) rx_state_d = R_DRAIN;
                    end
                end
            end
            R_CPL1: begin
                if (rx_beat) begin
                    cpl_match  = (tx_state_q == S_WAIT_CPL) && (rxData_in[15:8] == out_tag);
                    rx_state_d = rxEOP_in ? R_IDLE : R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (rx_beat && rxEOP_in) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // TX / command FSM: two-beat header emission, completion wait with timeout, response
    always_comb begin
        tx_state_d   = tx_state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        cmdReady_out = 1'b0;
        txValid_out  = 1'b0;
        txSOP_out    = 1'b0;
        txEOP_out    = 1'b0;
        txData_out   = 64'h0;
        rspValid_out = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                cmdReady_out = live_q;
                if (live_q && cmdValid_in) begin
                    addr_d     = cmdAddr_in[31:2];
                    wdata_d    = cmdWrData_in;
                    write_d    = cmdWrite_in;
                    tx_state_d = S_HDR;
                end
            end
            S_HDR: begin
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                txData_out  = qw0;
                if (txReady_in) tx_state_d = S_QW1;
            end
            S_QW1: begin
                txValid_out = 1'b1;
                txEOP_out   = 1'b1;
                txData_out  = qw1;
                if (txReady_in) begin
                    if (write_q) begin
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_state_d = S_WAIT_CPL;
                        cnt_d      = '0;
                        tag_d      = tag_q + 8'd1;
                    end
                end
            end
            S_WAIT_CPL: begin
                // a completion arriving on the timeout cycle takes priority
                if (cpl_match) begin
                    rsp_data_d = rxData_in[63:32];
                    rsp_err_d  = (status_q != 3'd0);
                    tx_state_d = S_RSP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = 32'hFFFF_FFFF;
                    rsp_err_d  = 1'b1;
                    tx_state_d = S_RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RSP: begin
                rspValid_out = 1'b1;
                if (rspReady_in) tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlp_requester.sv
// Bench for tlp_requester: a 16-cycle-timeout instance for most sequences and a
// default-timeout instance for the long RX-traffic-during-wait sequence.
module tb_tlp_requester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] req_id;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        cmd_write, cmd_valid, rsp_ready, tx_ready;
    logic [63:0] rx_data;
    logic        rx_valid, rx_sop, rx_eop;
    logic        use_long;

    logic        s_cmd_ready, s_rsp_error, s_rsp_valid, s_tx_valid, s_tx_sop, s_tx_eop, s_rx_ready;
    logic [31:0] s_rsp_data;
    logic [63:0] s_tx_data;
    logic [15:0] s_mwr_count;
    logic        l_cmd_ready, l_rsp_error, l_rsp_valid, l_tx_valid, l_tx_sop, l_tx_eop, l_rx_ready;
    logic [31:0] l_rsp_data;
    logic [63:0] l_tx_data;
    logic [15:0] l_mwr_count;

    logic        cmd_ready, rsp_error, rsp_valid, tx_valid, tx_sop, tx_eop, rx_ready;
    logic [31:0] rsp_data;
    logic [63:0] tx_data;
    logic [15:0] mwr_count;

    assign cmd_ready = use_long ? l_cmd_ready : s_cmd_ready;
    assign rsp_error = use_long ? l_rsp_error : s_rsp_error;
    assign rsp_valid = use_long ? l_rsp_valid : s_rsp_valid;
    assign rsp_data  = use_long ? l_rsp_data  : s_rsp_data;
    assign tx_valid  = use_long ? l_tx_valid  : s_tx_valid;
    assign tx_sop    = use_long ? l_tx_sop    : s_tx_sop;
    assign tx_eop    = use_long ? l_tx_eop    : s_tx_eop;
    assign tx_data   = use_long ? l_tx_data   : s_tx_data;
    assign rx_ready  = use_long ? l_rx_ready  : s_rx_ready;
    assign mwr_count = use_long ? l_mwr_count : s_mwr_count;

    tlp_requester #(.TIMEOUT_CYCLES(16)) u_dut (
        .pcieClk_in(clk), .pcieRstN_in(rst_n), .cfgReqID_in(req_id),
        .cmdAddr_in(cmd_addr), .cmdWrData_in(cmd_wdata), .cmdWrite_in(cmd_write),
        .cmdValid_in(cmd_valid & ~use_long), .cmdReady_out(s_cmd_ready),
        .rspData_out(s_rsp_data), .rspError_out(s_rsp_error),
        .rspValid_out(s_rsp_valid), .rspReady_in(rsp_ready),
        .txData_out(s_tx_data), .txValid_out(s_tx_valid), .txReady_in(tx_ready),
        .txSOP_out(s_tx_sop), .txEOP_out(s_tx_eop),
        .rxData_in(rx_data), .rxValid_in(rx_valid & ~use_long), .rxReady_out(s_rx_ready),
        .rxSOP_in(rx_sop), .rxEOP_in(rx_eop), .mwrCount_out(s_mwr_count)
    );

    tlp_requester u_dut_long (
        .pcieClk_in(clk), .pcieRstN_in(rst_n), .cfgReqID_in(req_id),
        .cmdAddr_in(cmd_addr), .cmdWrData_in(cmd_wdata), .cmdWrite_in(cmd_write),
        .cmdValid_in(cmd_valid & use_long), .cmdReady_out(l_cmd_ready),
        .rspData_out(l_rsp_data), .rspError_out(l_rsp_error),
        .rspValid_out(l_rsp_valid), .rspReady_in(rsp_ready),
        .txData_out(l_tx_data), .txValid_out(l_tx_valid), .txReady_in(tx_ready),
        .txSOP_out(l_tx_sop), .txEOP_out(l_tx_eop),
        .rxData_in(rx_data), .rxValid_in(rx_valid & use_long), .rxReady_out(l_rx_ready),
        .rxSOP_in(rx_sop), .rxEOP_in(rx_eop), .mwrCount_out(l_mwr_count)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] reqid;
        logic [7:0]  tag;
        logic [2:0]  st;
        logic [31:0] cdata;
        logic [63:0] qw0;
        logic [63:0] qw1;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [63:0] qw0, input logic [63:0] qw1);
        int w;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_valid = 1'b1;
        tx_ready  = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick;
            w++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        tick;
        cmd_valid = 1'b0;
        chk("hdr_valid", 64'(tx_valid), 64'd1);
        chk("hdr_sop", 64'(tx_sop), 64'd1);
        chk("hdr_eop", 64'(tx_eop), 64'd0);
        chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("qw0", tx_data, qw0);
        tick;
        chk("qw1_valid", 64'(tx_valid), 64'd1);
        chk("qw1_sop", 64'(tx_sop), 64'd0);
        chk("qw1_eop", 64'(tx_eop), 64'd1);
        chk("qw1", tx_data, qw1);
        tick;
        chk("tx_idle", 64'(tx_valid), 64'd0);
    endtask

    task automatic rx_beat(input logic [63:0] d, input logic sop, input logic eop);
        rx_data  = d;
        rx_sop   = sop;
        rx_eop   = eop;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic send_cpl(input logic [7:0] tag, input logic [2:0] st, input logic [31:0] data);
        rx_beat({16'h0000, st, 13'd4, 32'h4A00_0001}, 1'b1, 1'b0);
        rx_beat({data, req_id, tag, 8'h00}, 1'b0, 1'b1);
    endtask

    task automatic send_mwr18;
        for (int i = 0; i < 18; i++)
            rx_beat((i == 0) ? 64'h0000_0000_4000_0010 : 64'h0000_0000_4A00_0001, i == 0, i == 17);
    endtask

    task automatic take_rsp(input logic [31:0] data, input logic err);
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_data", 64'(rsp_data), 64'(data));
        chk("rsp_error", 64'(rsp_error), 64'(err));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("rsp_done", 64'(rsp_valid), 64'd0);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    task automatic chk_reset_vals;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_sop", 64'(tx_sop), 64'd0);
        chk("rst_tx_eop", 64'(tx_eop), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_mwr_count", 64'(mwr_count), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int beat;
        int n;
        logic [7:0] t;

        vecs[0] = '{1'b1, 32'h0000_000C, 32'h1234_5678, 16'h0100, 8'h00, 3'd0, 32'h0,
                    64'h0100_010F_4000_0001, 64'h1234_5678_0000_000C, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0018, 32'h0, 16'h0100, 8'h01, 3'd0, 32'hCAFE_F00D,
                    64'h0100_010F_0000_0001, 64'h0000_0000_0000_0018, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0103, 32'hA5A5_A5A5, 16'hBEEF, 8'h00, 3'd0, 32'h0,
                    64'hBEEF_020F_4000_0001, 64'hA5A5_A5A5_0000_0100, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 16'hBEEF, 8'h02, 3'd4, 32'h1122_3344,
                    64'hBEEF_020F_0000_0001, 64'h0000_0000_FFFF_FFFC, 32'h1122_3344, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0, 16'h0001, 8'h03, 3'd0, 32'h0000_0000,
                    64'h0001_030F_0000_0001, 64'h0000_0000_0000_0020, 32'h0, 1'b0};

        rst_n     = 1'b0;
        req_id    = 16'h0100;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_write = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tx_ready  = 1'b1;
        rx_data   = '0;
        rx_valid  = 1'b0;
        rx_sop    = 1'b0;
        rx_eop    = 1'b0;
        use_long  = 1'b0;

        // reset state, before and across clock edges
        #3;
        chk_reset_vals();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        tick;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_rx_ready", 64'(rx_ready), 64'd1);

        // read 0x14 with txReady toggling: beats held, valid never drops
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0014;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        beat = 0;
        for (int c = 0; c < 20 && beat < 2; c++) begin
            tx_ready = (c % 2 == 1);
            chk("stall_valid", 64'(tx_valid), 64'd1);
            chk("stall_sop", 64'(tx_sop), 64'(beat == 0));
            chk("stall_eop", 64'(tx_eop), 64'(beat == 1));
            chk("stall_data", tx_data,
                (beat == 0) ? 64'h0100_000F_0000_0001 : 64'h0000_0000_0000_0014);
            tick;
            if (tx_ready) beat++;
        end
        tx_ready = 1'b1;
        chk("stall_beats", 64'(beat), 64'd2);
        chk("stall_tx_idle", 64'(tx_valid), 64'd0);
        chk("wait_no_rsp", 64'(rsp_valid), 64'd0);
        send_cpl(8'h00, 3'd0, 32'hCAFE_F00D);
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_data0", 64'(rsp_data), 64'hCAFE_F00D);
        tick;
        chk("hold_data1", 64'(rsp_data), 64'hCAFE_F00D);
        take_rsp(32'hCAFE_F00D, 1'b0);
        tick;
        chk("rsp_data_kept", 64'(rsp_data), 64'hCAFE_F00D);

        // table of full transactions (tags continue from 01)
        for (int i = 0; i < 5; i++) begin
            req_id = vecs[i].reqid;
            send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].qw0, vecs[i].qw1);
            if (vecs[i].wr) begin
                tick;
                chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                send_cpl(vecs[i].tag, vecs[i].st, vecs[i].cdata);
                take_rsp(vecs[i].rdata, vecs[i].err);
            end
        end
        req_id = 16'h0100;

        // timeout after 16 waiting cycles, then a late completion is dropped
        send_cmd(1'b0, 32'h0000_0040, 32'h0, 64'h0100_040F_0000_0001, 64'h0000_0000_0000_0040);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick;
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd16);
        take_rsp(32'hFFFF_FFFF, 1'b1);
        send_cpl(8'h04, 3'd0, 32'h1212_1212);
        tick;
        chk("late_cpl_no_rsp", 64'(rsp_valid), 64'd0);
        chk("late_cpl_data", 64'(rsp_data), 64'hFFFF_FFFF);

        // long instance: wrong-tag CplD and three 18-QW MWr during the wait
        use_long = 1'b1;
        #1;
        send_cmd(1'b0, 32'h0000_0050, 32'h0, 64'h0100_000F_0000_0001, 64'h0000_0000_0000_0050);
        send_cpl(8'h01, 3'd0, 32'hBAD0_BAD0);
        chk("wrong_tag_no_rsp", 64'(rsp_valid), 64'd0);
        repeat (3) send_mwr18();
        chk("mwr_no_rsp", 64'(rsp_valid), 64'd0);
        chk("mwr_count", 64'(mwr_count), 64'd3);
        send_cpl(8'h00, 3'd0, 32'hDEAD_BEEF);
        take_rsp(32'hDEAD_BEEF, 1'b0);
        use_long = 1'b0;
        #1;
        chk("short_mwr_count", 64'(mwr_count), 64'd0);

        // 256 reads starting at tag 05: tag wraps FF->00 and returns to 05
        for (int i = 0; i < 256; i++) begin
            t = 8'(i + 5);
            send_cmd(1'b0, 32'h0000_0080, 32'h0, {16'h0100, t, 8'h0F, 32'h0000_0001},
                     64'h0000_0000_0000_0080);
            send_cpl(t, 3'd0, {24'h0, t});
            take_rsp({24'h0, t}, 1'b0);
        end
        send_cmd(1'b0, 32'h0000_0084, 32'h0, 64'h0100_050F_0000_0001, 64'h0000_0000_0000_0084);
        send_cpl(8'h05, 3'd4, 32'h0BAD_F00D);
        take_rsp(32'h0BAD_F00D, 1'b1);

        // reset pulse while QW1 is stalled
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0060;
        cmd_valid = 1'b1;
        tx_ready  = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        tx_ready = 1'b0;
        chk("pre_rst_qw1_eop", 64'(tx_eop), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        use_long = 1'b1;
        #1;
        chk("long_rst_mwr_count", 64'(mwr_count), 64'd0);
        use_long = 1'b0;
        @(posedge clk);
        #1;
        chk("in_rst_tx_valid", 64'(tx_valid), 64'd0);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        tick;
        chk("rerst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rerst_rx_ready", 64'(rx_ready), 64'd1);
        send_cmd(1'b1, 32'h0000_0008, 32'h55AA_55AA, 64'h0100_000F_4000_0001,
                 64'h55AA_55AA_0000_0008);
        chk("rerst_wr_no_rsp", 64'(rsp_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tlp_requester.md
TLP_REQUESTER -- requirements
Module: tlp_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles in S_WAIT_CPL before a read is failed.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-003 pcieClk_in  in  1  core clock; all state changes on its rising edge.
REQ-004 pcieRstN_in  in  1  asynchronous reset, active-low.
REQ-005 cfgReqID_in  in  16  requester ID placed in every emitted header.
REQ-006 cmdAddr_in  in  32  DW-aligned byte address; bits[1:0] ignored.
REQ-007 cmdWrData_in  in  32  write payload.
REQ-008 cmdWrite_in  in  1  1=memory write, 0=memory read.
REQ-009 cmdValid_in / cmdReady_out  in/out  1  command handshake.
REQ-010 rspData_out  out  32  read-completion data.
REQ-011 rspError_out  out  1  read failed (bad status or timeout).
REQ-012 rspValid_out / rspReady_in  out/in  1  response handshake.
REQ-013 txData_out  out  64 ; txValid_out  out  1 ; txReady_in  in  1 ; txSOP_out, txEOP_out  out  1 -- TLPs to the endpoint.
REQ-014 rxData_in  in  64 ; rxValid_in  in  1 ; rxReady_out  out  1 ; rxSOP_in, rxEOP_in  in  1 -- TLPs from the endpoint.
REQ-015 mwrCount_out  out  16  number of MWr TLPs received from the endpoint, wrapping.

Function
REQ-016 Header QW0 SHALL be {reqID[63:48], tag[47:40], lastBE=0[39:36], firstBE=F[35:32], DW0} with DW0 fmt[30:29], type[28:24]=0, length[9:0]=1, all other bits 0.
REQ-017 MWr QW0 fmt=2; QW1 = {cmdWrData, addr[31:2],2'b00}. MRd QW0 fmt=0; QW1 = {32'h0, addr[31:2],2'b00}.
REQ-018 TX FSM states: S_IDLE, S_HDR, S_QW1, S_WAIT_CPL, S_RSP.
REQ-019 cmdReady_out SHALL be 1 only in S_IDLE; on accept, latch addr, data and write flag, go to S_HDR.
REQ-020 S_HDR: txValid_out=1, txSOP_out=1, QW0 driven; on txReady_in go to S_QW1.
REQ-021 S_QW1: txValid_out=1, txEOP_out=1, QW1 driven; on txReady_in, write goes to S_IDLE, read goes to S_WAIT_CPL with timeout counter cleared.
REQ-022 txValid_out SHALL NOT deassert between SOP and EOP; txData_out SHALL be stable while txValid_out=1 and txReady_in=0.
REQ-023 Tag SHALL increment by 1 (8-bit wrap, FF->00) after each read QW1 is accepted; writes use the current tag without incrementing.
REQ-024 rxReady_out SHALL be 1 at all times out of reset; RX is never back-pressured.
REQ-025 RX FSM states: R_IDLE, R_CPL1, R_DRAIN. A beat counts only when rxValid_in=1.
REQ-026 In R_IDLE, SOP with fmt=2 and type=0x0A (CplD): capture status[47:45], go to R_CPL1. SOP with fmt in {2,3} and type=0: increment mwrCount_out. Any other SOP: ignore the TLP. If EOP is not set on the SOP beat, go to R_DRAIN.
REQ-027 R_CPL1: a completion matches when TX is in S_WAIT_CPL and QW1[15:8] equals the outstanding tag. On match: rspData_out = QW1[63:32], rspError_out = (status != 0), TX goes to S_RSP. Non-matching completions are discarded. RX returns to R_IDLE on EOP, else goes to R_DRAIN.
REQ-028 R_DRAIN: return to R_IDLE on the EOP beat.
REQ-029 S_WAIT_CPL: counter increments each cycle. On reaching TIMEOUT_CYCLES-1 with no match: rspData_out = FFFFFFFF, rspError_out = 1, go to S_RSP.
REQ-030 A match in the same cycle as the timeout SHALL win: data is taken from the completion.
REQ-031 S_RSP: rspValid_out=1 holding data and error; on rspReady_in go to S_IDLE. rspData_out and rspError_out SHALL hold their values until the next response.
REQ-032 Only one read SHALL be outstanding at a time; no new command is accepted until S_RSP completes.

Reset
REQ-033 While pcieRstN_in=0: both FSMs idle, tag=00, mwrCount_out=0, counters 0, cmdReady_out=0, txValid_out=0, txSOP_out=0, txEOP_out=0, rspValid_out=0, rspData_out=0, rspError_out=0, rxReady_out=0.
REQ-034 Reset asserted mid-TLP SHALL abort it immediately with no EOP emitted. After deassertion, cmdReady_out=1 and rxReady_out=1 on the first clock edge.

Verification
REQ-035 Write, addr=0x0000000C, data=0x12345678, reqID=0x0100, txReady_in=1 -> QW0 fmt=2, length=1, firstBE=F; QW1=0x12345678_0000000C; 2 tx cycles; no response.
REQ-036 Read, addr=0x14, with txReady_in toggling -> QW0 and QW1 held stable and txValid_out never drops; then CplD tag 00, status 0, data 0xCAFEF00D -> rspData_out=CAFEF00D, rspError_out=0; next read uses tag 01.
REQ-037 Read with no completion, TIMEOUT_CYCLES=16 -> rspValid_out after 16 cycles with rspData_out=FFFFFFFF, rspError_out=1; a late CplD is then discarded.
REQ-038 During a wait, a CplD with the wrong tag and three 18-QW MWr TLPs -> no response emitted and mwrCount_out=3; the correct-tag CplD afterwards completes the read.
REQ-039 256 reads -> tag wraps FF->00; a CplD with status=4 -> rspError_out=1.
REQ-040 pcieRstN_in pulsed low during S_QW1 -> txValid_out=0 immediately; all REQ-033 values hold; the next command is accepted normally.
